// File: rtl/axi4_sys_port_txn_gate.sv
// AXI4 transaction gate for the system port: caps outstanding reads/writes, orders W behind AW,
// supports a quiesce/drain handshake and flags unexpected responses and response timeouts.
module axi4_sys_port_txn_gate #(
    parameter int ID_W    = 4,
    parameter int ADDR_W  = 31,
    parameter int DATA_W  = 64,
    parameter int MAX_OUT = 8,
    parameter int TIMEOUT = 4096,
    parameter int CNT_W   = $clog2(MAX_OUT + 1)
) (
    input  logic                            clock,
    input  logic                            reset_n,

    input  logic                            s_aw_valid,
    output logic                            s_aw_ready,
    input  logic [ID_W+ADDR_W+12:0]         s_aw_bits,
    output logic                            m_aw_valid,
    input  logic                            m_aw_ready,
    output logic [ID_W+ADDR_W+12:0]         m_aw_bits,

    input  logic                            s_w_valid,
    output logic                            s_w_ready,
    input  logic [DATA_W+DATA_W/8:0]        s_w_bits,
    output logic                            m_w_valid,
    input  logic                            m_w_ready,
    output logic [DATA_W+DATA_W/8:0]        m_w_bits,

    input  logic                            s_ar_valid,
    output logic                            s_ar_ready,
    input  logic [ID_W+ADDR_W+12:0]         s_ar_bits,
    output logic                            m_ar_valid,
    input  logic                            m_ar_ready,
    output logic [ID_W+ADDR_W+12:0]         m_ar_bits,

    input  logic                            m_b_valid,
    output logic                            m_b_ready,
    input  logic [ID_W+1:0]                 m_b_bits,
    output logic                            s_b_valid,
    input  logic                            s_b_ready,
    output logic [ID_W+1:0]                 s_b_bits,

    input  logic                            m_r_valid,
    output logic                            m_r_ready,
    input  logic [ID_W+DATA_W+2:0]          m_r_bits,
    output logic                            s_r_valid,
    input  logic                            s_r_ready,
    output logic [ID_W+DATA_W+2:0]          s_r_bits,

    input  logic                            quiesce,
    output logic                            idle,
    output logic                            err_unexp_b,
    output logic                            err_unexp_r,
    output logic                            err_timeout,
    input  logic                            err_clear,
    output logic [CNT_W-1:0]                wr_out,
    output logic [CNT_W-1:0]                rd_out
);

    localparam int WD_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int WD_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUT);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(WD_LAST_I);
    localparam logic [WD_W-1:0]  WD_ZERO  = {WD_W{1'b0}};
    localparam logic [WD_W-1:0]  WD_ONE   = WD_W'(1);

    logic [CNT_W-1:0] wr_cnt_r, wr_cnt_nxt_s;
    logic [CNT_W-1:0] rd_cnt_r, rd_cnt_nxt_s;
    logic [CNT_W-1:0] w_pend_r, w_pend_nxt_s;
    logic [WD_W-1:0]  wd_cnt_r, wd_cnt_nxt_s;
    logic             err_unexp_b_r, err_unexp_r_r, err_timeout_r;
    logic             err_unexp_b_nxt_s, err_unexp_r_nxt_s, err_timeout_nxt_s;

    logic aw_ok_s, ar_ok_s, w_ok_s;
    logic aw_fire_s, ar_fire_s, w_last_fire_s, b_fire_s, r_fire_s, r_last_fire_s;
    logic unexp_b_s, unexp_r_s, timeout_hit_s, wd_clear_s;

    // Gating only looks at registered counts and quiesce, never at the ready on the same side.
    assign aw_ok_s = !quiesce && (wr_cnt_r < CNT_MAX) && (w_pend_r < CNT_MAX);
    assign ar_ok_s = !quiesce && (rd_cnt_r < CNT_MAX);
    assign w_ok_s  = (w_pend_r != CNT_ZERO);

    assign m_aw_valid = s_aw_valid & aw_ok_s;
    assign s_aw_ready = m_aw_ready & aw_ok_s;
    assign m_aw_bits  = s_aw_bits;
    assign m_ar_valid = s_ar_valid & ar_ok_s;
    assign s_ar_ready = m_ar_ready & ar_ok_s;
    assign m_ar_bits  = s_ar_bits;
    assign m_w_valid  = s_w_valid & w_ok_s;
    assign s_w_ready  = m_w_ready & w_ok_s;
    assign m_w_bits   = s_w_bits;

    assign s_b_valid  = m_b_valid;
    assign m_b_ready  = s_b_ready;
    assign s_b_bits   = m_b_bits;
    assign s_r_valid  = m_r_valid;
    assign m_r_ready  = s_r_ready;
    assign s_r_bits   = m_r_bits;

    assign aw_fire_s     = s_aw_valid & s_aw_ready;
    assign ar_fire_s     = s_ar_valid & s_ar_ready;
    assign w_last_fire_s = s_w_valid & s_w_ready & s_w_bits[0];
    assign b_fire_s      = m_b_valid & s_b_ready;
    assign r_fire_s      = m_r_valid & s_r_ready;
    assign r_last_fire_s = r_fire_s & m_r_bits[0];

    // Next-state for outstanding counters; a response with nothing outstanding is flagged, not counted.
    always_comb begin
        wr_cnt_nxt_s = wr_cnt_r;
        rd_cnt_nxt_s = rd_cnt_r;
        w_pend_nxt_s = w_pend_r;
        unexp_b_s    = 1'b0;
        unexp_r_s    = 1'b0;

        if (aw_fire_s && !b_fire_s) begin
            wr_cnt_nxt_s = wr_cnt_r + CNT_ONE;
        end else if (b_fire_s && !aw_fire_s) begin
            if (wr_cnt_r != CNT_ZERO) begin
                wr_cnt_nxt_s = wr_cnt_r - CNT_ONE;
            end else begin
                unexp_b_s = 1'b1;
            end
        end else begin
            wr_cnt_nxt_s = wr_cnt_r;
        end

        if (ar_fire_s && !r_last_fire_s) begin
            rd_cnt_nxt_s = rd_cnt_r + CNT_ONE;
        end else if (r_last_fire_s && !ar_fire_s) begin
            if (rd_cnt_r != CNT_ZERO) begin
                rd_cnt_nxt_s = rd_cnt_r - CNT_ONE;
            end else begin
                unexp_r_s = 1'b1;
            end
        end else begin
            rd_cnt_nxt_s = rd_cnt_r;
        end

        // A last beat can only fire while w_pend is non-zero, so no underflow check is needed.
        if (aw_fire_s && !w_last_fire_s) begin
            w_pend_nxt_s = w_pend_r + CNT_ONE;
        end else if (w_last_fire_s && !aw_fire_s) begin
            w_pend_nxt_s = w_pend_r - CNT_ONE;
        end else begin
            w_pend_nxt_s = w_pend_r;
        end
    end

    assign wd_clear_s = ((wr_cnt_r == CNT_ZERO) && (rd_cnt_r == CNT_ZERO)) || b_fire_s || r_fire_s;

    // Response watchdog; with TIMEOUT of zero WD_MAX is zero and the counter never leaves zero.
    always_comb begin
        wd_cnt_nxt_s  = wd_cnt_r;
        timeout_hit_s = 1'b0;
        if (wd_clear_s) begin
            wd_cnt_nxt_s = WD_ZERO;
        end else if (wd_cnt_r != WD_MAX) begin
            wd_cnt_nxt_s  = wd_cnt_r + WD_ONE;
            timeout_hit_s = (wd_cnt_r == WD_LAST);
        end else begin
            wd_cnt_nxt_s = wd_cnt_r;
        end
    end

    // Sticky error flags; a clear wins over a set arriving in the same cycle.
    always_comb begin
        err_unexp_b_nxt_s = err_unexp_b_r;
        err_unexp_r_nxt_s = err_unexp_r_r;
        err_timeout_nxt_s = err_timeout_r;
        if (err_clear) begin
            err_unexp_b_nxt_s = 1'b0;
            err_unexp_r_nxt_s = 1'b0;
            err_timeout_nxt_s = 1'b0;
        end else begin
            err_unexp_b_nxt_s = err_unexp_b_r | unexp_b_s;
            err_unexp_r_nxt_s = err_unexp_r_r | unexp_r_s;
            err_timeout_nxt_s = err_timeout_r | timeout_hit_s;
        end
    end

    // State registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_cnt_r      <= CNT_ZERO;
            rd_cnt_r      <= CNT_ZERO;
            w_pend_r      <= CNT_ZERO;
            wd_cnt_r      <= WD_ZERO;
            err_unexp_b_r <= 1'b0;
            err_unexp_r_r <= 1'b0;
            err_timeout_r <= 1'b0;
        end else begin
            wr_cnt_r      <= wr_cnt_nxt_s;
            rd_cnt_r      <= rd_cnt_nxt_s;
            w_pend_r      <= w_pend_nxt_s;
            wd_cnt_r      <= wd_cnt_nxt_s;
            err_unexp_b_r <= err_unexp_b_nxt_s;
            err_unexp_r_r <= err_unexp_r_nxt_s;
            err_timeout_r <= err_timeout_nxt_s;
        end
    end

    assign wr_out      = wr_cnt_r;
    assign rd_out      = rd_cnt_r;
    assign err_unexp_b = err_unexp_b_r;
    assign err_unexp_r = err_unexp_r_r;
    assign err_timeout = err_timeout_r;
    assign idle        = quiesce && (wr_cnt_r == CNT_ZERO) && (rd_cnt_r == CNT_ZERO)
                         && (w_pend_r == CNT_ZERO);

endmodule

// File: doc/axi4_sys_port_txn_gate.md
Name: axi4_sys_port_txn_gate

Overview:
Parametrised AXI4 transaction gate that sits between the TileLink-to-AXI4 bridge and the external AXI4 system port. It caps outstanding reads and writes per direction and blocks W beats until their AW has been accepted. It also provides a quiesce/drain handshake for power and reset sequencing, and flags unexpected responses and response timeouts. Channel payloads pass through unmodified; only valid/ready are gated.

Parameters:
ID_W, 4, AXI ID width
ADDR_W, 31, address width
DATA_W, 64, data width (STRB_W = DATA_W/8)
MAX_OUT, 8, max outstanding transactions per direction (1..255)
TIMEOUT, 4096, cycles without a response while outstanding before timeout flags (0 disables)
CNT_W, derived clog2(MAX_OUT+1), counter width

Ports:
clock  in  1  sole clock
reset_n  in  1  asynchronous active-low reset
s_aw_valid/s_aw_ready  in/out  1  upstream AW handshake
s_aw_bits  in  ID_W+ADDR_W+13  {id,addr,len[7:0],size[2:0],burst[1:0]}
m_aw_valid/m_aw_ready  out/in  1  downstream AW handshake
m_aw_bits  out  ID_W+ADDR_W+13  = s_aw_bits
s_w_valid/s_w_ready, m_w_valid/m_w_ready  1  W handshakes
s_w_bits/m_w_bits  in/out  DATA_W+STRB_W+1  {data,strb,last}
s_ar_*/m_ar_*  as AW
m_b_valid/m_b_ready, s_b_valid/s_b_ready  1  B handshakes (downstream to upstream)
m_b_bits/s_b_bits  in/out  ID_W+2  {id,resp}
m_r_valid/m_r_ready, s_r_valid/s_r_ready  1  R handshakes
m_r_bits/s_r_bits  in/out  ID_W+DATA_W+3  {id,data,resp,last}
quiesce  in  1  block new AW/AR
idle  out  1  quiesce and nothing outstanding
err_unexp_b, err_unexp_r, err_timeout  out  1  sticky error flags
err_clear  in  1  clears all sticky flags
wr_out, rd_out  out  CNT_W  outstanding counts

Behaviour:
- Reset (async assert, sync deassert by upstream): wr_cnt=rd_cnt=w_pend=wd_cnt=0, all err_* = 0, idle = quiesce.
- aw_ok = !quiesce & (wr_cnt < MAX_OUT) & (w_pend < MAX_OUT). m_aw_valid = s_aw_valid & aw_ok; s_aw_ready = m_aw_ready & aw_ok. No combinational path from ready to valid on the same side.
- ar_ok = !quiesce & (rd_cnt < MAX_OUT); AR gated the same way.
- W: w_ok = (w_pend != 0), using the registered value. A W beat is never forwarded in the cycle its AW is accepted (one-cycle minimum AW→W). W is not blocked by quiesce.
- w_pend: +1 on AW fire, -1 on W fire with last; both in the same cycle → unchanged.
- wr_cnt: +1 on AW fire, -1 on B fire; both → unchanged.
- rd_cnt: +1 on AR fire, -1 on R fire with last; both → unchanged.
- B/R pass through ungated: s_b_valid = m_b_valid, m_b_ready = s_b_ready; same for R.
- B fire with wr_cnt==0 and no same-cycle AW fire: err_unexp_b ← 1 and wr_cnt stays 0 (no underflow). R fire with last and rd_cnt==0: err_unexp_r, same rule.
- Watchdog wd_cnt: cleared when wr_cnt==0 & rd_cnt==0, or on any B fire or R fire. Otherwise increments and saturates at TIMEOUT. err_timeout ← 1 when wd_cnt reaches TIMEOUT-1 and increments. Traffic continues after a timeout.
- err_clear has priority over a same-cycle set: flags clear that cycle; a new error on the next cycle sets the flag again.
- idle = quiesce & wr_cnt==0 & rd_cnt==0 & w_pend==0, built from registered counters.
- quiesce deasserting mid-drain immediately re-opens AW/AR; counts are unaffected.
- Counters are CNT_W wide and can never exceed MAX_OUT, so no wrap-around is possible.

Test Plan:
- MAX_OUT=8: issue 9 ARs with m_r_valid=0 → 8 forwarded, s_ar_ready=0 on the 9th, rd_out=8. One R with last → 9th AR fires the next cycle.
- AW and W presented in the same cycle, len=3 → m_w_valid held low in the AW cycle, 4 beats forwarded afterwards, w_pend returns 0 after the beat with last.
- AW fire and B fire in the same cycle with wr_cnt=3 → wr_cnt stays 3. B with wr_cnt=0 → err_unexp_b=1 and wr_cnt=0. Then err_clear → flag 0.
- 2 writes outstanding, quiesce=1 → new AW blocked, idle=0. Deliver both W bursts and both Bs → idle=1 the cycle after the last B.
- TIMEOUT=16, one AR outstanding, no R → err_timeout=1 after 16 cycles. An R beat restarts the watchdog.
- reset_n asserted with 5 reads outstanding → rd_out=0, all err_*=0, m_*_valid follows the gating immediately.
